// File: rtl/bus_memory_slave_if.sv
// Bus bundle between a bus master and bus_memory_slave.
// Names keep the established *IN / *OUT form of the existing bus.
// IN signals are driven by the master.
// OUT signals are driven by the slave.
interface bus_memory_slave_if;
    logic [31:0] address_dataIN;
    logic [3:0]  byte_enableIN;
    logic [7:0]  burst_sizeIN;
    logic        read_n_writeIN;
    logic        begin_transactionIN;
    logic        end_transactionIN;
    logic        data_validIN;
    logic        busyIN;
    logic [31:0] address_dataOUT;
    logic        end_transactionOUT;
    logic        data_validOUT;
    logic        busyOUT;
    logic        errorOUT;

    modport master (
        output address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
               begin_transactionIN, end_transactionIN, data_validIN, busyIN,
        input  address_dataOUT, end_transactionOUT, data_validOUT, busyOUT, errorOUT
    );

    modport slave (
        input  address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
               begin_transactionIN, end_transactionIN, data_validIN, busyIN,
        output address_dataOUT, end_transactionOUT, data_validOUT, busyOUT, errorOUT
    );
endinterface

// File: rtl/bus_memory_slave.sv
// bus_memory_slave: 256 x 32 word memory behind a 1 KiB bus window.
//
// Transfer behaviour
// - Burst writes use latched byte enables.
// - Burst reads use a registered memory read.
// - The first read word appears two cycles after the begin cycle.
// - busyIN back-pressure holds the current read word.
// - A master abort is accepted during a read.
//
// Optional build macro: BUS_MEMORY_SLAVE_ERROR_CHECK_EN
// - When defined, a selected begin goes to the ERROR state if either:
//   - the address is misaligned, or
//   - the burst would run past word 255.
// - When undefined:
//   - address bits [1:0] are ignored,
//   - the word index wraps modulo 256,
//   - errorOUT is tied low.
module bus_memory_slave #(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    bus_memory_slave_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        READ     = 3'd2,
        READ_END = 3'd3,
        ERROR    = 3'd4
    } state_t;

    state_t      state_r;
    logic [31:0] mem_r [0:255];
    logic [7:0]  index_r;
    logic [3:0]  be_r;
    logic [8:0]  count_r;
    logic [31:0] data_out_r;
    logic        data_valid_r;
    logic        end_out_r;

    logic        select_s;
    logic        err_s;
    logic        mem_we_s;

    // The block is addressed only when the upper address bits hit the window.
    assign select_s = bus.begin_transactionIN &&
                      (bus.address_dataIN[31:10] == BASE_ADDRESS[31:10]);

    // A write beat is stored only while words remain in the burst.
    assign mem_we_s = (state_r == WRITE) && bus.data_validIN && (count_r != 9'd0);

`ifdef BUS_MEMORY_SLAVE_ERROR_CHECK_EN
    logic error_r;

    // Flag a misaligned start address.
    // Also flag a burst whose last word would fall beyond index 255.
    always_comb begin
        err_s = 1'b0;
        if ((bus.address_dataIN[1:0] != 2'b00) ||
            (({1'b0, bus.address_dataIN[9:2]} + {1'b0, bus.burst_sizeIN}) > 9'd255)) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // errorOUT pulses for exactly the one cycle spent in the ERROR state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            error_r <= 1'b0;
        end else begin
            error_r <= (state_r == IDLE) && select_s && err_s;
        end
    end

    assign bus.errorOUT = error_r;
`else
    logic unused_addr_lsb_s;

    assign err_s             = 1'b0;
    assign unused_addr_lsb_s = ^bus.address_dataIN[1:0];
    assign bus.errorOUT      = 1'b0;
`endif

    // Memory array write port.
    // Byte lanes are gated by the enables latched at begin.
    // The array has no reset, so its contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_r[i]) begin
                    mem_r[index_r][8*i +: 8] <= bus.address_dataIN[8*i +: 8];
                end
            end
        end
    end

    // Transaction FSM, with the registered read data and handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            index_r      <= 8'd0;
            be_r         <= 4'd0;
            count_r      <= 9'd0;
            data_out_r   <= 32'd0;
            data_valid_r <= 1'b0;
            end_out_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    data_out_r   <= 32'd0;
                    data_valid_r <= 1'b0;
                    end_out_r    <= 1'b0;
                    if (select_s) begin
                        index_r <= bus.address_dataIN[9:2];
                        be_r    <= bus.byte_enableIN;
                        count_r <= {1'b0, bus.burst_sizeIN} + 9'd1;
                        if (err_s) begin
                            state_r   <= ERROR;
                            end_out_r <= 1'b1;
                        end else if (bus.read_n_writeIN) begin
                            state_r <= READ;
                        end else begin
                            state_r <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_we_s) begin
                        index_r <= index_r + 8'd1;
                        count_r <= count_r - 9'd1;
                    end
                    if (bus.end_transactionIN) begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    if (bus.end_transactionIN) begin
                        // Master abort: drop everything, no end pulse.
                        state_r      <= IDLE;
                        data_out_r   <= 32'd0;
                        data_valid_r <= 1'b0;
                    end else if (!data_valid_r) begin
                        // First read cycle: fetch the first word.
                        data_out_r   <= mem_r[index_r];
                        data_valid_r <= 1'b1;
                        index_r      <= index_r + 8'd1;
                    end else if (bus.busyIN) begin
                        // Master stalled: hold the current word.
                        data_out_r   <= data_out_r;
                        data_valid_r <= 1'b1;
                    end else if (count_r == 9'd1) begin
                        // Last beat accepted.
                        count_r      <= 9'd0;
                        data_out_r   <= 32'd0;
                        data_valid_r <= 1'b0;
                        end_out_r    <= 1'b1;
                        state_r      <= READ_END;
                    end else begin
                        // Beat accepted: present the next word straight away.
                        count_r    <= count_r - 9'd1;
                        data_out_r <= mem_r[index_r];
                        index_r    <= index_r + 8'd1;
                    end
                end
                READ_END: begin
                    end_out_r <= 1'b0;
                    state_r   <= IDLE;
                end
                ERROR: begin
                    end_out_r <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    data_out_r   <= 32'd0;
                    data_valid_r <= 1'b0;
                    end_out_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.address_dataOUT    = data_out_r;
    assign bus.data_validOUT      = data_valid_r;
    assign bus.end_transactionOUT = end_out_r;
    assign bus.busyOUT            = 1'b0;

endmodule

// File: tb/tb_bus_memory_slave.sv
// Self-checking bench for bus_memory_slave.
// A word-array model tracks the expected memory contents.
// Handshake timing is derived from the transfer rules.
// Honours BUS_MEMORY_SLAVE_ERROR_CHECK_EN when it is defined.
module tb_bus_memory_slave;

    localparam logic [31:0] BASE = 32'h4000_0400;
`ifdef BUS_MEMORY_SLAVE_ERROR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [31:0] model_mem [0:255];
    logic [31:0] wdata     [0:255];

    bus_memory_slave_if bus();

    bus_memory_slave #(.BASE_ADDRESS(BASE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {28'd0, bus.errorOUT, bus.end_transactionOUT, bus.data_validOUT,
                bus.busyOUT, bus.address_dataOUT};
    endfunction

    function automatic logic [63:0] pk(input logic e, input logic en, input logic dv,
                                       input logic [31:0] d);
        return {28'd0, e, en, dv, 1'b0, d};
    endfunction

    function automatic logic in_win(input logic [31:0] a);
        return a[31:10] == BASE[31:10];
    endfunction

    function automatic logic pred_err(input logic [31:0] a, input logic [7:0] b);
        return ERR_EN && ((a[1:0] != 2'b00) || ((int'(a[9:2]) + int'(b)) > 255));
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.address_dataIN      = 32'd0;
        bus.byte_enableIN       = 4'd0;
        bus.burst_sizeIN        = 8'd0;
        bus.read_n_writeIN      = 1'b0;
        bus.begin_transactionIN = 1'b0;
        bus.end_transactionIN   = 1'b0;
        bus.data_validIN        = 1'b0;
        bus.busyIN              = 1'b0;
    endtask

    task automatic merge(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    task automatic drive_begin(input logic [31:0] a, input logic [3:0] be,
                               input logic [7:0] b, input logic rnw);
        bus.begin_transactionIN = 1'b1;
        bus.address_dataIN      = a;
        bus.byte_enableIN       = be;
        bus.burst_sizeIN        = b;
        bus.read_n_writeIN      = rnw;
        tick();
        bus.begin_transactionIN = 1'b0;
        bus.address_dataIN      = 32'd0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] be, input logic [7:0] b,
                            input bit gaps, input bit end_with_last, input bit extra);
        logic [7:0] idx;
        int n;
        int nb;
        bit ended;
        logic dv;
        idx = a[9:2];
        nb  = int'(b) + 1;
        drive_begin(a, be, b, 1'b0);
        if (!in_win(a)) begin
            for (int c = 0; c < nb + 2; c++) begin
                chk("outside_wr", outs(), 64'd0);
                bus.data_validIN   = 1'b1;
                bus.address_dataIN = $urandom;
                tick();
            end
            idle_inputs();
            chk("outside_wr_end", outs(), 64'd0);
            return;
        end
        if (pred_err(a, b)) begin
            chk("wr_err_pulse", outs(), pk(1'b1, 1'b1, 1'b0, 32'd0));
            bus.data_validIN   = 1'b1;
            bus.address_dataIN = $urandom;
            tick();
            idle_inputs();
            chk("wr_err_done", outs(), 64'd0);
            return;
        end
        n = 0;
        ended = 1'b0;
        while (n < nb) begin
            chk("wr_quiet", outs(), 64'd0);
            dv = !(gaps && ($urandom_range(0, 2) == 0));
            bus.data_validIN   = dv;
            bus.address_dataIN = wdata[n];
            if (dv && (n == nb - 1) && end_with_last) begin
                bus.end_transactionIN = 1'b1;
                ended = 1'b1;
            end
            tick();
            if (dv) begin
                merge(idx + 8'(n), be, wdata[n]);
                n++;
            end
        end
        bus.end_transactionIN = 1'b0;
        if (extra && !ended) begin
            chk("wr_quiet_extra", outs(), 64'd0);
            bus.data_validIN   = 1'b1;
            bus.address_dataIN = $urandom;
            tick();
        end
        if (!ended) begin
            bus.data_validIN      = 1'b0;
            bus.end_transactionIN = 1'b1;
            tick();
        end
        idle_inputs();
        chk("wr_done", outs(), 64'd0);
    endtask

    // busy_mode: 0 none, 1 random, 2 busy_len cycles at beat busy_beat
    task automatic do_read(input logic [31:0] a, input logic [7:0] b, input int busy_mode,
                           input int busy_beat, input int busy_len, input int abort_beat);
        logic [7:0] idx;
        int nb;
        int beat;
        int held;
        logic bsy;
        idx = a[9:2];
        nb  = int'(b) + 1;
        drive_begin(a, 4'hF, b, 1'b1);
        if (!in_win(a)) begin
            for (int c = 0; c < nb + 3; c++) begin
                chk("outside_rd", outs(), 64'd0);
                tick();
            end
            return;
        end
        if (pred_err(a, b)) begin
            chk("rd_err_pulse", outs(), pk(1'b1, 1'b1, 1'b0, 32'd0));
            tick();
            chk("rd_err_done", outs(), 64'd0);
            return;
        end
        chk("rd_latency", outs(), 64'd0);
        tick();
        beat = 0;
        held = 0;
        while (beat < nb) begin
            chk("rd_beat", outs(), pk(1'b0, 1'b0, 1'b1, model_mem[idx + 8'(beat)]));
            if (beat == abort_beat) begin
                bus.end_transactionIN = 1'b1;
                tick();
                bus.end_transactionIN = 1'b0;
                chk("rd_abort", outs(), 64'd0);
                return;
            end
            bsy = 1'b0;
            if (busy_mode == 2 && beat == busy_beat && held < busy_len) bsy = 1'b1;
            if (busy_mode == 1 && held < 3 && $urandom_range(0, 3) == 0) bsy = 1'b1;
            bus.busyIN = bsy;
            tick();
            bus.busyIN = 1'b0;
            if (bsy) begin
                held++;
            end else begin
                beat++;
                if (busy_mode == 1) held = 0;
            end
        end
        chk("rd_end_pulse", outs(), pk(1'b0, 1'b1, 1'b0, 32'd0));
        tick();
        chk("rd_idle", outs(), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  b;
        int          ab;

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        chk("reset_state", outs(), 64'd0);
        reset = 1'b0;
        tick();
        chk("post_reset_idle", outs(), 64'd0);

        // Preload every word so that all later reads have known contents.
        for (int i = 0; i < 256; i++) wdata[i] = $urandom;
        do_write(BASE, 4'hF, 8'd255, 1'b0, 1'b1, 1'b0);
        do_read(BASE, 8'd255, 0, 0, 0, -1);

        // Basic burst write, then read back.
        for (int i = 0; i < 4; i++) wdata[i] = 32'hA0 + 32'(i);
        do_write(BASE + 32'h10, 4'hF, 8'd3, 1'b0, 1'b1, 1'b0);
        do_read(BASE + 32'h10, 8'd3, 0, 0, 0, -1);

        // Partial byte-enable merge.
        wdata[0] = 32'h1111_2222;
        do_write(BASE + 32'h20, 4'hF, 8'd0, 1'b0, 1'b0, 1'b0);
        wdata[0] = 32'hDEAD_BEEF;
        do_write(BASE + 32'h20, 4'b0011, 8'd0, 1'b0, 1'b1, 1'b0);
        do_read(BASE + 32'h20, 8'd0, 0, 0, 0, -1);

        // Write with gaps, then discarded surplus beats.
        for (int i = 0; i < 6; i++) wdata[i] = $urandom;
        do_write(BASE + 32'h40, 4'hF, 8'd5, 1'b1, 1'b0, 1'b1);
        do_read(BASE + 32'h40, 8'd5, 0, 0, 0, -1);

        // Back-pressure on beat 2 for 3 cycles.
        do_read(BASE + 32'h80, 8'd7, 2, 2, 3, -1);

        // Master abort at beat 3, then an immediate new begin.
        do_read(BASE + 32'h80, 8'd7, 0, 0, 0, 3);
        do_read(BASE + 32'h10, 8'd3, 0, 0, 0, -1);

        // Accesses outside the window stay silent and leave memory alone.
        do_read(BASE ^ 32'h0100_0000, 8'd7, 0, 0, 0, -1);
        for (int i = 0; i < 8; i++) wdata[i] = $urandom;
        do_write((BASE ^ 32'h0000_0400) + 32'h80, 4'hF, 8'd7, 1'b0, 1'b0, 1'b0);
        do_read(BASE + 32'h80, 8'd7, 0, 0, 0, -1);

        // Burst starting near the top of the window.
        // Error pulse when checking is enabled, index wrap otherwise.
        for (int i = 0; i < 4; i++) wdata[i] = 32'hC0DE_0000 + 32'(i);
        do_write(BASE + 32'h3F8, 4'hF, 8'd3, 1'b0, 1'b1, 1'b0);
        do_read(BASE + 32'h3F8, 8'd1, 0, 0, 0, -1);
        do_read(BASE, 8'd1, 0, 0, 0, -1);
        do_read(BASE + 32'h12, 8'd0, 0, 0, 0, -1);

        // Asynchronous reset while read data is on the bus.
        drive_begin(BASE + 32'h0C8, 4'hF, 8'd7, 1'b1);
        tick();
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_rd", outs(), 64'd0);
        tick();
        reset = 1'b0;
        idle_inputs();
        chk("after_reset_rd", outs(), 64'd0);

        // Reset in the middle of a write burst: stored words persist.
        for (int i = 0; i < 8; i++) wdata[i] = $urandom;
        drive_begin(BASE + 32'h190, 4'hF, 8'd7, 1'b0);
        for (int n = 0; n < 3; n++) begin
            bus.data_validIN   = 1'b1;
            bus.address_dataIN = wdata[n];
            tick();
            merge(8'd100 + 8'(n), 4'hF, wdata[n]);
        end
        bus.data_validIN = 1'b0;
        #3;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        do_read(BASE + 32'h190, 8'd7, 0, 0, 0, -1);

        // Randomised mix of transactions.
        for (int t = 0; t < 40; t++) begin
            a = {BASE[31:10], 8'($urandom), 2'b00};
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 11) == 0) a = a ^ 32'h0010_0000;
            b = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < 16; i++) wdata[i] = $urandom;
                do_write(a, 4'($urandom), b, 1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, int'(b)) : -1;
                do_read(a, b, 1, 0, 0, ab);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_memory_slave.md
BUS_MEMORY_SLAVE -- requirements
Module: bus_memory_slave

Interface
REQ-001 Parameter BASE_ADDRESS, default 32'h0000_0000, meaning base of the 1 KiB window; bits [9:0] are ignored.
REQ-002 clock  input  1  single clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 address_dataIN  input  32  address in the begin cycle, write data in data cycles.
REQ-005 byte_enableIN  input  4  byte lanes, sampled in the begin cycle.
REQ-006 burst_sizeIN  input  8  number of words minus 1, sampled in the begin cycle.
REQ-007 read_n_writeIN  input  1  1 = read, 0 = write, sampled in the begin cycle.
REQ-008 begin_transactionIN, end_transactionIN, data_validIN, busyIN  input  1 each  master-side handshake.
REQ-009 address_dataOUT  output  32  read data; 0 when not driving.
REQ-010 end_transactionOUT, data_validOUT, busyOUT, errorOUT  output  1 each  slave-side handshake; 0 when idle.

Function
REQ-011 The block SHALL contain a 256 x 32 memory, word index = address[9:2].
REQ-012 The block SHALL be selected only when begin_transactionIN=1 and address[31:10] equals BASE_ADDRESS[31:10]; otherwise it SHALL stay IDLE and keep all outputs 0.
REQ-013 FSM states SHALL be IDLE, WRITE, READ, READ_END, ERROR; begin_transactionIN SHALL be ignored outside IDLE.
REQ-014 IDLE->WRITE on a selected write begin; latch the word index, byte enables, and word count = burst_sizeIN+1.
REQ-015 In WRITE, each cycle with data_validIN=1 SHALL store address_dataIN using the latched byte enables, increment the index, and decrement the count.
REQ-016 In WRITE, busyOUT SHALL stay 0; data beats after the count reaches 0 SHALL be discarded.
REQ-017 In WRITE, end_transactionIN SHALL return the FSM to IDLE, and a data beat in the same cycle SHALL still be stored.
REQ-018 IDLE->READ on a selected read begin.
REQ-019 The first data_validOUT SHALL occur 2 cycles after the begin cycle; the memory read is registered.
REQ-020 In READ, when busyIN=1 with data_validOUT=1, the block SHALL hold address_dataOUT and data_validOUT, and the beat SHALL NOT count.
REQ-021 A read beat SHALL count when data_validOUT=1 and busyIN=0; the next word SHALL appear on the next cycle, with no gaps.
REQ-022 After the last counted read beat, the FSM SHALL enter READ_END, pulse end_transactionOUT for exactly 1 cycle, then enter IDLE.
REQ-023 In READ, end_transactionIN (master abort) SHALL force IDLE on the next cycle, with all outputs 0 and no end_transactionOUT.
REQ-024 The word index SHALL wrap modulo 256 (e.g. 255->0) unless REQ-031 applies.
REQ-025 address_dataOUT SHALL be 0 whenever data_validOUT=0.
REQ-026 In ERROR, errorOUT and end_transactionOUT SHALL both be high for exactly 1 cycle, then the FSM SHALL enter IDLE; write data in the meantime SHALL be discarded.

Reset
REQ-027 reset SHALL asynchronously force IDLE and clear all outputs, the latched index, the count, and the byte enables.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 Reset mid-burst SHALL abort the transfer; words already written SHALL persist.

Configuration
REQ-030 The macro BUS_MEMORY_SLAVE_ERROR_CHECK_EN SHALL control the error check.
REQ-031 With BUS_MEMORY_SLAVE_ERROR_CHECK_EN defined, a selected begin SHALL go to ERROR in either case: address[1:0] != 0, or word index + burst_sizeIN > 255.
REQ-032 Without BUS_MEMORY_SLAVE_ERROR_CHECK_EN, address[1:0] SHALL be ignored, wrap per REQ-024 SHALL apply, and errorOUT SHALL be tied to 0.

Verification
REQ-033 Write begin addr=BASE+0x10, be=4'hF, burst=3, data 0xA0..0xA3, then a read of the same range -> data_validOUT at +2 cycles, words 0xA0..0xA3, 1-cycle end_transactionOUT.
REQ-034 Write with be=4'b0011, data 0xDEADBEEF over 0x11112222 -> read returns 0x1111BEEF.
REQ-035 Read burst=7 with busyIN high for 3 cycles at beat 2 -> beat 2 held stable for 3 cycles, 8 words total, end pulse after the last.
REQ-036 Read burst=7 with end_transactionIN at beat 3 -> outputs 0 next cycle, no end_transactionOUT, and a new begin is accepted 1 cycle later.
REQ-037 Begin with addr outside the window (bits [31:10] differ) -> all outputs stay 0 for the whole burst.
REQ-038 With the macro: addr=BASE+0x3F8, burst=3 -> errorOUT and end_transactionOUT pulse 1 cycle, memory unchanged. Without the macro: same stimulus -> index wraps 254,255,0,1.
